// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered N:1 mux (mux_nx1_reg) and its round-robin picker.
package mux_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Channel-index width; never below one bit so a port can always be declared.
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req, searching ptr, ptr+1, ... wrapping at N-1.
// Zero latency; no handshake of its own.
module rr_pick
  import mux_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = sel_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Walk the rotated request vector and map the winner back to its channel index.
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = SW'(j);
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mux_nx1_reg.sv
// N:1 mux with manual/scan selection and one registered output stage (one cycle grant-to-output, full throughput).
// Optional out_par (even parity of out_data) when MUX_PARITY_EN is defined.
module mux_nx1_reg
  import mux_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = sel_w(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N-1:0]    ch_mask,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   out_ch,
`ifdef MUX_PARITY_EN
  output logic            out_par,
`endif
  output logic            sel_err
);

  state_t        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic          sel_err_q, sel_err_d;

  logic          ld;
  logic          xfer;
  logic [SW-1:0] xfer_ch;
  logic [W-1:0]  sel_data;
  logic [N-1:0]  rr_gnt;
  logic [SW-1:0] rr_idx;
  logic          rr_any;

  assign ld = !out_valid_q || out_ready;

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .req (in_valid & ch_mask),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  always_comb begin
    state_d   = (mode == MODE_SCAN) ? SCAN : MANUAL;
    in_ready  = '0;
    xfer      = 1'b0;
    xfer_ch   = '0;
    sel_err_d = 1'b0;

    // Grant uses the registered state, so a mode change lands one cycle later.
    if (state_q == MANUAL) begin
      if (int'(sel) < N) begin
        if (ld && in_valid[sel]) begin
          xfer    = 1'b1;
          xfer_ch = sel;
        end
      end else begin
        sel_err_d = ld;
      end
    end else if (ld && rr_any) begin
      xfer    = 1'b1;
      xfer_ch = rr_idx;
    end
    if (xfer) in_ready[xfer_ch] = 1'b1;

    ptr_d = ptr_q;
    if (state_q == MANUAL && state_d == SCAN)
      ptr_d = '0;
    else if (state_q == SCAN && xfer)
      ptr_d = (int'(xfer_ch) == N - 1) ? '0 : xfer_ch + 1'b1;

    sel_data    = in_data[int'(xfer_ch)*W +: W];
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (ld) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = sel_data;
        out_ch_d   = xfer_ch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MANUAL;
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      sel_err_q   <= sel_err_d;
    end
  end

`ifdef MUX_PARITY_EN
  logic out_par_q, out_par_d;

  always_comb begin
    out_par_d = out_par_q;
    if (ld && xfer) out_par_d = ^sel_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_par_q <= 1'b0;
    else        out_par_q <= out_par_d;
  end

  assign out_par = out_par_q;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Directed bench for mux_nx1_reg: N=8 table of vectors plus N=6 out-of-range and async-reset sequences.
module tb_mux_nx1_reg;

  logic        clk;
  logic        rst_n;

  // N=8 instance
  logic [63:0] in_data;
  logic [7:0]  in_valid, in_ready, ch_mask;
  logic        mode, out_valid, out_ready, sel_err;
  logic [2:0]  sel, out_ch;
  logic [7:0]  out_data;
`ifdef MUX_PARITY_EN
  logic        out_par;
`endif

  // N=6 instance
  logic [47:0] d6;
  logic [5:0]  v6, r6, m6;
  logic        mode6, ov6, ordy6, err6;
  logic [2:0]  sel6, ch6;
  logic [7:0]  od6;
`ifdef MUX_PARITY_EN
  logic        par6;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic       mode;
    logic [2:0] sel;
    logic [7:0] valid;
    logic [7:0] mask;
    logic       ordy;
    logic [7:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_dat;
    logic [2:0] exp_ch;
  } vec_t;

  vec_t tbl[$];

  mux_nx1_reg #(.N(8), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .ch_mask(ch_mask), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch),
`ifdef MUX_PARITY_EN
    .out_par(out_par),
`endif
    .sel_err(sel_err)
  );

  mux_nx1_reg #(.N(6), .W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(d6), .in_valid(v6), .in_ready(r6),
    .mode(mode6), .sel(sel6), .ch_mask(m6), .out_data(od6), .out_valid(ov6),
    .out_ready(ordy6), .out_ch(ch6),
`ifdef MUX_PARITY_EN
    .out_par(par6),
`endif
    .sel_err(err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic add(input logic m, input logic [2:0] s, input logic [7:0] v, input logic [7:0] mk,
                     input logic r, input logic [7:0] er, input logic eov, input logic [7:0] ed,
                     input logic [2:0] ec);
    vec_t t;
    t.mode = m; t.sel = s; t.valid = v; t.mask = mk; t.ordy = r;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_dat = ed; t.exp_ch = ec;
    tbl.push_back(t);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    mode = 1'b0; sel = '0; in_valid = '0; ch_mask = '0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) in_data[c*8 +: 8] = 8'h10 + 8'(c);
    mode6 = 1'b0; sel6 = '0; v6 = '0; m6 = '0; ordy6 = 1'b1;
    for (int c = 0; c < 6; c++) d6[c*8 +: 8] = 8'h20 + 8'(c);

    // Manual sweep, ch data 0x10+c
    for (int s = 0; s < 8; s++)
      add(1'b0, 3'(s), 8'hFF, 8'h00, 1'b1, 8'(1 << s), 1'b1, 8'h10 + 8'(s), 3'(s));
    // Backpressure after a ch3 beat, then release straight into ch5
    add(1'b0, 3'd3, 8'hFF, 8'h00, 1'b1, 8'h08, 1'b1, 8'h13, 3'd3);
    for (int i = 0; i < 3; i++)
      add(1'b0, 3'd5, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h13, 3'd3);
    add(1'b0, 3'd5, 8'hFF, 8'h00, 1'b1, 8'h20, 1'b1, 8'h15, 3'd5);
    // Selected channel not valid: no grant, data/ch held
    add(1'b0, 3'd1, 8'hFD, 8'h00, 1'b1, 8'h00, 1'b0, 8'h15, 3'd5);
    // Switch to scan with nothing valid; manual state still in force this cycle
    add(1'b1, 3'd1, 8'h00, 8'hA5, 1'b1, 8'h00, 1'b0, 8'h15, 3'd5);
    // Scan over mask 1010_0101: 0,2,5,7,0,2
    add(1'b1, 3'd1, 8'hFF, 8'hA5, 1'b1, 8'h01, 1'b1, 8'h10, 3'd0);
    add(1'b1, 3'd1, 8'hFF, 8'hA5, 1'b1, 8'h04, 1'b1, 8'h12, 3'd2);
    add(1'b1, 3'd1, 8'hFF, 8'hA5, 1'b1, 8'h20, 1'b1, 8'h15, 3'd5);
    add(1'b1, 3'd1, 8'hFF, 8'hA5, 1'b1, 8'h80, 1'b1, 8'h17, 3'd7);
    add(1'b1, 3'd1, 8'hFF, 8'hA5, 1'b1, 8'h01, 1'b1, 8'h10, 3'd0);
    add(1'b1, 3'd1, 8'hFF, 8'hA5, 1'b1, 8'h04, 1'b1, 8'h12, 3'd2);
    // Nothing eligible: valid drops, pointer holds at 3 so next winner is ch5
    add(1'b1, 3'd1, 8'h00, 8'hA5, 1'b1, 8'h00, 1'b0, 8'h12, 3'd2);
    add(1'b1, 3'd1, 8'hFF, 8'hA5, 1'b1, 8'h20, 1'b1, 8'h15, 3'd5);

    #12;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_ch", 32'(out_ch), 32'd0);
    chk("reset sel_err", 32'(sel_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      mode = tbl[i].mode; sel = tbl[i].sel; in_valid = tbl[i].valid;
      ch_mask = tbl[i].mask; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
      tick();
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
      chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(tbl[i].exp_dat));
      chk($sformatf("v%0d out_ch", i), 32'(out_ch), 32'(tbl[i].exp_ch));
      chk($sformatf("v%0d sel_err", i), 32'(sel_err), 32'd0);
    end

    // Async reset between edges, mid-scan
    #2;
    rst_n = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 32'd0);
    chk("async out_data", 32'(out_data), 32'd0);
    chk("async out_ch", 32'(out_ch), 32'd0);
    chk("async sel_err", 32'(sel_err), 32'd0);
    in_valid = 8'h00;
    #1;
    rst_n = 1'b1;
    tick();
    chk("post-reset idle out_valid", 32'(out_valid), 32'd0);
    in_valid = 8'hFF;
    #1;
    chk("post-reset rdy0", 32'(in_ready), 32'h01);
    tick();
    chk("post-reset ch0", 32'(out_ch), 32'd0);
    chk("post-reset data0", 32'(out_data), 32'h10);
    #1;
    chk("post-reset rdy1", 32'(in_ready), 32'h04);
    tick();
    chk("post-reset ch2", 32'(out_ch), 32'd2);

    // N=6: out-of-range select
    v6 = 6'h3F; sel6 = 3'd2;
    tick();
    chk("n6 ch2", 32'(ch6), 32'd2);
    chk("n6 data2", 32'(od6), 32'h22);
    sel6 = 3'd6;
    #1;
    chk("n6 oor in_ready", 32'(r6), 32'd0);
    tick();
    chk("n6 oor sel_err", 32'(err6), 32'd1);
    chk("n6 oor out_valid", 32'(ov6), 32'd0);
    chk("n6 oor ch held", 32'(ch6), 32'd2);
    sel6 = 3'd1;
    tick();
    chk("n6 sel_err clears", 32'(err6), 32'd0);
    chk("n6 ch1 valid", 32'(ov6), 32'd1);
    chk("n6 ch1", 32'(ch6), 32'd1);

`ifdef MUX_PARITY_EN
    mode = 1'b0; in_valid = 8'h00; out_ready = 1'b1;
    tick();
    in_data[7:0] = 8'h07; in_data[15:8] = 8'h03;
    sel = 3'd0; in_valid = 8'hFF;
    tick();
    chk("par 07", 32'(out_par), 32'd1);
    out_ready = 1'b0; sel = 3'd1;
    tick();
    tick();
    chk("par held", 32'(out_par), 32'd1);
    chk("par held data", 32'(out_data), 32'h07);
    out_ready = 1'b1;
    tick();
    chk("par 03", 32'(out_par), 32'd0);
    chk("par 03 data", 32'(out_data), 32'h03);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
